layer_alpha_blender: RTL and testbench

- Parametrised successor to the single-winner palette layer mux.
- Takes NUM_LAYERS palette-resolved ARGB pixels (alpha + RGB per layer) and composites them back-to-front with true fractional alpha blending over a programmable background colour.
- Pipelined at one layer per stage; advances only on pixel-clock-enable ticks.
- Sits between the palette lookup stage and the video output/DAC stage.

---
 rtl/layer_alpha_blender.sv | 124 ++++++++++++
 tb/tb_layer_alpha_blender.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/layer_alpha_blender.sv
// layer_alpha_blender: pipelined back-to-front fractional alpha compositor of NUM_LAYERS ARGB layers over a background.
// Optional per-layer enable mask input when LAYER_MASK_EN is defined.
module layer_alpha_blender #(
  parameter int NUM_LAYERS = 5,
  parameter int COLOR_BITS = 8,
  parameter int ALPHA_BITS = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [3:0]                          pc_ena_in,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0]  layer_rgb_in,
  input  logic [NUM_LAYERS*ALPHA_BITS-1:0]    layer_alpha_in,
  input  logic [3*COLOR_BITS-1:0]             bg_color_in,
`ifdef LAYER_MASK_EN
  input  logic [NUM_LAYERS-1:0]               layer_mask_in,
`endif
  input  logic                                vid_active_in,
  input  logic                                hs_in,
  input  logic                                vs_in,
  output logic [COLOR_BITS-1:0]               pixel_out_r,
  output logic [COLOR_BITS-1:0]               pixel_out_g,
  output logic [COLOR_BITS-1:0]               pixel_out_b,
  output logic                                vid_active_out,
  output logic                                hs_out,
  output logic                                vs_out
);
  localparam int CB = COLOR_BITS;
  localparam int AB = ALPHA_BITS;
  localparam int N  = NUM_LAYERS;
  localparam int CW = 3 * CB;
  localparam int RW = N * CW;
  localparam int AW = N * AB;
  localparam int IW = CB + AB + 1;
  localparam logic [AB:0]   A_ONE = {1'b1, {AB{1'b0}}};
  localparam logic [IW-1:0] RND   = IW'(1) << (AB - 1);

  logic          tick;
  logic [N-1:0]  en;
  logic [RW-1:0] rgb_q [N];
  logic [RW-1:0] rgb_d [N];
  logic [AW-1:0] a_q   [N];
  logic [AW-1:0] a_d   [N];
  logic [CW-1:0] acc_q [N+1];
  logic [CW-1:0] acc_d [N+1];
  logic [2:0]    sb_q  [N+1];
  logic [2:0]    sb_d  [N+1];
  logic [CW-1:0] pix_q;
  logic [2:0]    sbo_q;

  assign tick = pc_ena_in == 4'd0;
`ifdef LAYER_MASK_EN
  assign en = layer_mask_in;
`else
  assign en = '1;
`endif

  // Alpha is stretched so all-ones maps to exactly 2^AB, making opaque and transparent exact.
  function automatic logic [CB-1:0] blend_ch(input logic [CB-1:0] src, input logic [CB-1:0] acc,
                                             input logic [AB-1:0] a);
    logic [AB:0]   ax;
    logic [IW-1:0] sum;
    ax  = {1'b0, a} + {{AB{1'b0}}, a[AB-1]};
    sum = IW'(src) * IW'(ax) + IW'(acc) * IW'(A_ONE - ax) + RND;
    return sum[AB +: CB];
  endfunction

  function automatic logic [CW-1:0] blend_px(input logic [CW-1:0] src, input logic [CW-1:0] acc,
                                             input logic [AB-1:0] a);
    logic [CW-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) r[c*CB +: CB] = blend_ch(src[c*CB +: CB], acc[c*CB +: CB], a);
    return r;
  endfunction

  always_comb begin
    rgb_d[0] = layer_rgb_in;
    a_d[0]   = '0;
    for (int i = 0; i < N; i++)
      a_d[0][i*AB +: AB] = (vid_active_in && en[i]) ? layer_alpha_in[i*AB +: AB] : '0;
    acc_d[0] = vid_active_in ? bg_color_in : '0;
    sb_d[0]  = {vid_active_in, hs_in, vs_in};
    for (int k = 1; k < N; k++) begin
      rgb_d[k] = rgb_q[k-1];
      a_d[k]   = a_q[k-1];
    end
    for (int k = 1; k <= N; k++) begin
      acc_d[k] = blend_px(rgb_q[k-1][(N-k)*CW +: CW], acc_q[k-1], a_q[k-1][(N-k)*AB +: AB]);
      sb_d[k]  = sb_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        rgb_q[k] <= '0;
        a_q[k]   <= '0;
      end
      for (int k = 0; k <= N; k++) begin
        acc_q[k] <= '0;
        sb_q[k]  <= '0;
      end
      pix_q <= '0;
      sbo_q <= '0;
    end else if (tick) begin
      for (int k = 0; k < N; k++) begin
        rgb_q[k] <= rgb_d[k];
        a_q[k]   <= a_d[k];
      end
      for (int k = 0; k <= N; k++) begin
        acc_q[k] <= acc_d[k];
        sb_q[k]  <= sb_d[k];
      end
      pix_q <= acc_q[N];
      sbo_q <= sb_q[N];
    end
  end

  assign pixel_out_r    = pix_q[2*CB +: CB];
  assign pixel_out_g    = pix_q[CB +: CB];
  assign pixel_out_b    = pix_q[0 +: CB];
  assign vid_active_out = sbo_q[2];
  assign hs_out         = sbo_q[1];
  assign vs_out         = sbo_q[0];
endmodule

// File: tb/tb_layer_alpha_blender.sv
// tb_layer_alpha_blender: scoreboard bench; expected pixels are queued at each tick and popped as the DUT emits them.
module tb_layer_alpha_blender;
  localparam int N  = 5;
  localparam int CB = 8;
  localparam int AB = 4;
  localparam int CW = 3 * CB;
  localparam int W  = 3 + CW;
`ifdef LAYER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      pc_ena_in = '0;
  logic [N*CW-1:0] layer_rgb_in = '0;
  logic [N*AB-1:0] layer_alpha_in = '0;
  logic [CW-1:0]   bg_color_in = '0;
  logic [N-1:0]    mask = '1;
  logic            vid_active_in = 1'b0;
  logic            hs_in = 1'b0;
  logic            vs_in = 1'b0;
  logic [CB-1:0]   pixel_out_r, pixel_out_g, pixel_out_b;
  logic            vid_active_out, hs_out, vs_out;
  logic            cyc = 1'b0;
  logic [1:0]      ph = '0;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    cur = '0;
  string           tag = "reset";
  int              checks = 0;
  int              errors = 0;

  layer_alpha_blender #(.NUM_LAYERS(N), .COLOR_BITS(CB), .ALPHA_BITS(AB)) dut (
    .clk(clk), .reset(reset), .pc_ena_in(pc_ena_in),
    .layer_rgb_in(layer_rgb_in), .layer_alpha_in(layer_alpha_in), .bg_color_in(bg_color_in),
`ifdef LAYER_MASK_EN
    .layer_mask_in(mask),
`endif
    .vid_active_in(vid_active_in), .hs_in(hs_in), .vs_in(vs_in),
    .pixel_out_r(pixel_out_r), .pixel_out_g(pixel_out_g), .pixel_out_b(pixel_out_b),
    .vid_active_out(vid_active_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_out();
    return {vid_active_out, hs_out, vs_out, pixel_out_r, pixel_out_g, pixel_out_b};
  endfunction

  task automatic check(input string t, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", t, got, exp);
    end
  endtask

  // Reference compositor straight from the blend equation, using plain integers.
  function automatic logic [W-1:0] model();
    int acc[3];
    int ap, src;
    logic [N-1:0] en;
    en = mask | {N{!MASK_EN}};
    for (int c = 0; c < 3; c++) acc[c] = vid_active_in ? int'(bg_color_in[(2-c)*CB +: CB]) : 0;
    for (int i = N - 1; i >= 0; i--) begin
      ap = (vid_active_in && en[i]) ? int'(layer_alpha_in[i*AB +: AB]) : 0;
      ap = ap + (ap >> (AB - 1));
      for (int c = 0; c < 3; c++) begin
        src = int'(layer_rgb_in[i*CW + (2-c)*CB +: CB]);
        acc[c] = (src * ap + acc[c] * ((1 << AB) - ap) + (1 << (AB - 1))) >> AB;
      end
    end
    return {vid_active_in, hs_in, vs_in, CB'(acc[0]), CB'(acc[1]), CB'(acc[2])};
  endfunction

  initial begin
    logic t;
    forever begin
      @(posedge clk);
      if (!reset) begin
        t = pc_ena_in == 4'd0;
        if (t) exp_q.push_back(model());
        #1;
        if (t) begin
          if (exp_q.size() == 0) check({tag, "_underflow"}, dut_out(), '1);
          else cur = exp_q.pop_front();
        end
        check(t ? tag : {tag, "_hold"}, dut_out(), cur);
      end
    end
  end

  task automatic flush_model();
    exp_q.delete();
    for (int i = 0; i < N + 1; i++) exp_q.push_back('0);
    cur = '0;
  endtask

  task automatic send(input logic [N*CW-1:0] rgb, input logic [N*AB-1:0] a, input logic [CW-1:0] bg,
                      input logic va, input logic hs, input logic vs);
    do begin
      @(negedge clk);
      ph = cyc ? ph + 2'd1 : 2'd0;
      pc_ena_in = {2'b00, ph};
      if (ph != 2'd0) begin
        layer_rgb_in   = {$urandom, $urandom, $urandom, $urandom};
        layer_alpha_in = N*AB'($urandom);
        bg_color_in    = CW'($urandom);
        vid_active_in  = $urandom_range(0, 1) == 1;
        hs_in          = $urandom_range(0, 1) == 1;
        vs_in          = $urandom_range(0, 1) == 1;
      end
    end while (ph != 2'd0);
    layer_rgb_in   = rgb;
    layer_alpha_in = a;
    bg_color_in    = bg;
    vid_active_in  = va;
    hs_in          = hs;
    vs_in          = vs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_async", dut_out(), '0);
    flush_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [N*CW-1:0] rgb;
    #1;
    check("reset_init", dut_out(), '0);
    flush_model();
    @(negedge clk);
    reset = 1'b0;
    tag = "idle";
    idle(10);
    tag = "opaque_front";
    rgb = '1;
    rgb[0 +: CW] = 24'h123456;
    send(rgb, '1, '0, 1'b1, 1'b0, 1'b0);
    tag = "transparent_bg";
    send({$urandom, $urandom, $urandom, $urandom}, '0, 24'hAABBCC, 1'b1, 1'b1, 1'b0);
    tag = "inactive_bg";
    send({$urandom, $urandom, $urandom, $urandom}, '0, 24'hAABBCC, 1'b0, 1'b0, 1'b1);
    tag = "half_blend";
    rgb = '0;
    rgb[0 +: CW] = 24'hFF0080;
    send(rgb, N*AB'(8), 24'h00FF80, 1'b1, 1'b0, 1'b0);
    send(rgb, N*AB'(7), 24'h00FF80, 1'b1, 1'b0, 1'b0);
    tag = "random";
    for (int i = 0; i < 12; i++)
      send({$urandom, $urandom, $urandom, $urandom}, N*AB'($urandom), CW'($urandom), 1'b1, i[0], i[1]);
    tag = "stall";
    cyc = 1'b1;
    for (int i = 0; i < 20; i++)
      send({$urandom, $urandom, $urandom, $urandom}, N*AB'($urandom), CW'($urandom),
           $urandom_range(0, 3) != 0, i[0], ~i[0]);
    cyc = 1'b0;
    tag = "mid_reset";
    send({$urandom, $urandom, $urandom, $urandom}, '1, CW'($urandom), 1'b1, 1'b1, 1'b1);
    do_reset();
    tag = "post_reset";
    rgb = '0;
    rgb[0 +: CW] = 24'h5A6B7C;
    send(rgb, N*AB'(15), '0, 1'b1, 1'b1, 1'b0);
    idle(3);
`ifdef LAYER_MASK_EN
    tag = "mask_hide";
    rgb = '0;
    rgb[0 +: CW]  = 24'hFF0000;
    rgb[CW +: CW] = 24'h00FF00;
    mask = 5'b11110;
    send(rgb, {{(N-2)*AB{1'b0}}, 4'hF, 4'hF}, '0, 1'b1, 1'b0, 1'b0);
    tag = "mask_show";
    mask = 5'b11111;
    send(rgb, {{(N-2)*AB{1'b0}}, 4'hF, 4'hF}, '0, 1'b1, 1'b0, 1'b0);
`endif
    tag = "drain";
    idle(N + 3);
    check("queue_depth", W'(exp_q.size()), W'(N + 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
